// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: mem_signals bit map, access size codes, FSM states.
`default_nettype none

package mips_pkg;

  localparam int MS_READ     = 0;
  localparam int MS_WRITE    = 1;
  localparam int MS_SIZE_LO  = 2;
  localparam int MS_SIZE_HI  = 3;
  localparam int MS_UNSIGNED = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// Combinational store lane replication / byte enables and load lane extract / extension.
`default_nettype none

module mem_lane_align
  import mips_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [1:0]         st_addr_lo,
  input  logic [1:0]         st_size,
  input  logic [NB_DATA-1:0] st_data,
  output logic [3:0]         st_be,
  output logic [NB_DATA-1:0] st_wdata,
  input  logic [1:0]         ld_addr_lo,
  input  logic [1:0]         ld_size,
  input  logic               ld_unsigned,
  input  logic [NB_DATA-1:0] ld_rdata,
  output logic [NB_DATA-1:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
  assign half_sel = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  // Size 11 is reserved and falls through to the word path on both sides.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_rdata;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_data = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller (IDLE/BUSY/DONE req-ready handshake, stall, load align).
// Optional watchdog on BUSY enabled by defining MEM_TIMEOUT_EN.
`default_nettype none

module mem_access_unit
  import mips_pkg::*;
#(
  parameter int NB_DATA        = 32,
  parameter int NB_REGWR       = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NB_DATA-1:0]  alu_result_i,
  input  logic [NB_DATA-1:0]  data_wr_to_mem_i,
  input  logic [5:0]          mem_signals_i,
  input  logic [NB_REGWR-1:0] writeReg_i,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [NB_DATA-1:0]  dmem_addr_o,
  output logic [3:0]          dmem_be_o,
  output logic [NB_DATA-1:0]  dmem_wdata_o,
  input  logic [NB_DATA-1:0]  dmem_rdata_i,
  input  logic                dmem_ready_i,
  output logic                stall_o,
  output logic [NB_DATA-1:0]  load_data_o,
  output logic [NB_REGWR-1:0] load_reg_o,
  output logic                load_valid_o,
  output logic                misalign_o
);

  mem_state_e state, state_next;

  logic [1:0]          size_in;
  logic                access, is_half, is_word, misaligned, timeout;
  logic [3:0]          st_be;
  logic [NB_DATA-1:0]  st_wdata, ld_data;

  logic                we_q, unsigned_q, err_q;
  logic [1:0]          size_q, addr_lo_q;
  logic [NB_DATA-1:0]  addr_q, wdata_q, load_data_q;
  logic [3:0]          be_q;
  logic [NB_REGWR-1:0] wreg_q, load_reg_q;

  logic unused_sig;
  assign unused_sig = mem_signals_i[5];

  assign size_in    = mem_signals_i[MS_SIZE_HI:MS_SIZE_LO];
  assign access     = mem_signals_i[MS_READ] | mem_signals_i[MS_WRITE];
  assign is_half    = (size_in == SZ_HALF);
  assign is_word    = size_in[1];
  assign misaligned = (is_half & alu_result_i[0]) | (is_word & (alu_result_i[1:0] != 2'b00));

  mem_lane_align #(.NB_DATA(NB_DATA)) u_align (
    .st_addr_lo  (alu_result_i[1:0]),
    .st_size     (size_in),
    .st_data     (data_wr_to_mem_i),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_addr_lo  (addr_lo_q),
    .ld_size     (size_q),
    .ld_unsigned (unsigned_q),
    .ld_rdata    (dmem_rdata_i),
    .ld_data     (ld_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counter is zero on every BUSY entry because it is held clear while IDLE.
  always_ff @(posedge clock) begin
    if (!reset || state != ST_BUSY) tmo_cnt <= '0;
    else                            tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign timeout = (state == ST_BUSY) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_o = access;
        if (access) state_next = misaligned ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (dmem_ready_i || timeout) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_lo_q   <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'b0000;
      wreg_q      <= '0;
      load_data_q <= '0;
      load_reg_q  <= '0;
    end else begin
      if (state == ST_IDLE && access) begin
        err_q <= misaligned;
        if (!misaligned) begin
          addr_q     <= {alu_result_i[NB_DATA-1:2], 2'b00};
          addr_lo_q  <= alu_result_i[1:0];
          be_q       <= st_be;
          wdata_q    <= st_wdata;
          we_q       <= mem_signals_i[MS_WRITE];
          size_q     <= size_in;
          unsigned_q <= mem_signals_i[MS_UNSIGNED];
          wreg_q     <= writeReg_i;
        end
      end
      if (state == ST_BUSY) begin
        if (dmem_ready_i) begin
          if (!we_q) begin
            load_data_q <= ld_data;
            load_reg_q  <= wreg_q;
          end
        end else if (timeout) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign dmem_req_o   = (state == ST_BUSY);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign load_data_o  = load_data_q;
  assign load_reg_o   = load_reg_q;
  assign load_valid_o = (state == ST_DONE) & ~we_q & ~err_q;
  assign misalign_o   = (state == ST_DONE) & err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus hand sequences, event scoreboard.
`default_nettype none

module tb_mem_access_unit;

  localparam int EV_NONE = 0;
  localparam int EV_LOAD = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  sig;
    logic [4:0]  wreg;
    logic [31:0] rdata;
    int          delay;
    int          ev;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_load;
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [4:0]  wreg;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] alu_result_i, data_wr_to_mem_i, dmem_rdata_i;
  logic [5:0]  mem_signals_i;
  logic [4:0]  writeReg_i;
  logic        dmem_ready_i;
  logic        dmem_req_o, dmem_we_o, stall_o, load_valid_o, misalign_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, load_data_o;
  logic [3:0]  dmem_be_o;
  logic [4:0]  load_reg_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_vec  = -1;
  exp_t sb[$];
  vec_t vecs[15];

  mem_access_unit dut (
    .clock            (clock),
    .reset            (reset),
    .alu_result_i     (alu_result_i),
    .data_wr_to_mem_i (data_wr_to_mem_i),
    .mem_signals_i    (mem_signals_i),
    .writeReg_i       (writeReg_i),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_rdata_i     (dmem_rdata_i),
    .dmem_ready_i     (dmem_ready_i),
    .stall_o          (stall_o),
    .load_data_o      (load_data_o),
    .load_reg_o       (load_reg_o),
    .load_valid_o     (load_valid_o),
    .misalign_o       (misalign_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got 0x%08h, expected 0x%08h", name, cur_vec, act, exp);
    end
  endtask

  // Scoreboard: every load-valid or error pulse must match the oldest queued expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    #2;
    if (load_valid_o || misalign_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event (vec %0d): load_valid=%0b misalign=%0b, expected no event",
                 cur_vec, load_valid_o, misalign_o);
      end else begin
        e = sb.pop_front();
        check("event_kind", load_valid_o ? EV_LOAD : EV_ERR, e.kind);
        if (load_valid_o) begin
          check("load_data", load_data_o, e.data);
          check("load_reg", {27'd0, load_reg_o}, {27'd0, e.wreg});
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   stalls, busy, exp_stalls, exp_busy;
    bit   done, access, is_store;
    exp_t e;
    stalls   = 0;
    busy     = 0;
    done     = 1'b0;
    access   = v.sig[0] | v.sig[1];
    is_store = v.sig[1];
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clock);
      if (k == 0) begin
        alu_result_i     = v.addr;
        data_wr_to_mem_i = v.data;
        mem_signals_i    = v.sig;
        writeReg_i       = v.wreg;
        dmem_rdata_i     = v.rdata;
        if (v.ev != EV_NONE) begin
          e.kind = v.ev;
          e.data = v.exp_load;
          e.wreg = v.wreg;
          sb.push_back(e);
        end
      end
      #1;
      if (stall_o) stalls++;
      if (dmem_req_o) begin
        busy++;
        check("req_we", {31'd0, dmem_we_o}, {31'd0, is_store});
        check("req_addr", dmem_addr_o, v.exp_addr);
        if (is_store) begin
          check("req_be", {28'd0, dmem_be_o}, {28'd0, v.be});
          check("req_wdata", dmem_wdata_o, v.exp_wdata);
        end
        dmem_ready_i = (busy == v.delay);
      end else begin
        dmem_ready_i = 1'b0;
      end
      if (!stall_o) begin
        done          = 1'b1;
        mem_signals_i = 6'd0;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout (vec %0d): stall_o still 1 after 40 cycles, expected release", cur_vec);
      mem_signals_i = 6'd0;
      dmem_ready_i  = 1'b0;
    end
    exp_stalls = !access ? 0 : (v.ev == EV_ERR ? 1 : 1 + v.delay);
    exp_busy   = (!access || v.ev == EV_ERR) ? 0 : v.delay;
    check("stall_cycles", stalls, exp_stalls);
    check("busy_cycles", busy, exp_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //           addr      data          sig    wreg   rdata         dly ev       be     wdata         addr      load
    vecs[0]  = '{32'h10, 32'hDEADBEEF, 6'h0A, 5'd0,  32'h0,        2, EV_NONE, 4'hF, 32'hDEADBEEF, 32'h10, 32'h0};
    vecs[1]  = '{32'h13, 32'h000000A5, 6'h02, 5'd0,  32'h0,        1, EV_NONE, 4'h8, 32'hA5A5A5A5, 32'h10, 32'h0};
    vecs[2]  = '{32'h22, 32'h0,        6'h01, 5'd7,  32'h1280FF00, 1, EV_LOAD, 4'h0, 32'h0,        32'h20, 32'hFFFFFF80};
    vecs[3]  = '{32'h22, 32'h0,        6'h11, 5'd8,  32'h1280FF00, 1, EV_LOAD, 4'h0, 32'h0,        32'h20, 32'h00000080};
    vecs[4]  = '{32'h06, 32'h0,        6'h05, 5'd9,  32'h80017FFE, 3, EV_LOAD, 4'h0, 32'h0,        32'h04, 32'hFFFF8001};
    vecs[5]  = '{32'h05, 32'h0,        6'h09, 5'd10, 32'h0,        1, EV_ERR,  4'h0, 32'h0,        32'h0,  32'h0};
    vecs[6]  = '{32'h0E, 32'h1234ABCD, 6'h06, 5'd0,  32'h0,        1, EV_NONE, 4'hC, 32'hABCDABCD, 32'h0C, 32'h0};
    vecs[7]  = '{32'h02, 32'h0,        6'h15, 5'd11, 32'hF00D1234, 2, EV_LOAD, 4'h0, 32'h0,        32'h00, 32'h0000F00D};
    vecs[8]  = '{32'h08, 32'h0,        6'h09, 5'd12, 32'hCAFEBABE, 1, EV_LOAD, 4'h0, 32'h0,        32'h08, 32'hCAFEBABE};
    vecs[9]  = '{32'h14, 32'h0BADF00D, 6'h0B, 5'd13, 32'h0,        1, EV_NONE, 4'hF, 32'h0BADF00D, 32'h14, 32'h0};
    vecs[10] = '{32'h03, 32'h0,        6'h06, 5'd0,  32'h0,        1, EV_ERR,  4'h0, 32'h0,        32'h0,  32'h0};
    vecs[11] = '{32'h3C, 32'h0,        6'h00, 5'd0,  32'h0,        0, EV_NONE, 4'h0, 32'h0,        32'h0,  32'h0};
    vecs[12] = '{32'h1C, 32'h0,        6'h2D, 5'd14, 32'h00000001, 1, EV_LOAD, 4'h0, 32'h0,        32'h1C, 32'h00000001};
    vecs[13] = '{32'h01, 32'h0,        6'h01, 5'd15, 32'h00007F00, 2, EV_LOAD, 4'h0, 32'h0,        32'h00, 32'h0000007F};
    vecs[14] = '{32'h1A, 32'h0,        6'h0D, 5'd16, 32'h0,        1, EV_ERR,  4'h0, 32'h0,        32'h0,  32'h0};

    reset            = 1'b0;
    alu_result_i     = 32'h0;
    data_wr_to_mem_i = 32'h0;
    mem_signals_i    = 6'd0;
    writeReg_i       = 5'd0;
    dmem_rdata_i     = 32'h0;
    dmem_ready_i     = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_valid", {31'd0, load_valid_o}, 32'd0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    check("rst_load_data", load_data_o, 32'd0);
    check("rst_addr", dmem_addr_o, 32'd0);
    check("rst_be", {28'd0, dmem_be_o}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Reset asserted in the middle of a BUSY load abandons it; a late ready is ignored.
    cur_vec = 100;
    @(negedge clock);
    alu_result_i  = 32'h40;
    mem_signals_i = 6'h09;
    writeReg_i    = 5'd4;
    dmem_rdata_i  = 32'hAAAA5555;
    #1;
    check("rb_idle_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clock);
    #1;
    check("rb_busy_req", {31'd0, dmem_req_o}, 32'd1);
    reset         = 1'b0;
    mem_signals_i = 6'd0;
    @(negedge clock);
    #1;
    check("rb_after_rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rb_after_rst_stall", {31'd0, stall_o}, 32'd0);
    reset        = 1'b1;
    dmem_ready_i = 1'b1;
    @(negedge clock);
    #1;
    check("rb_late_ready_req", {31'd0, dmem_req_o}, 32'd0);
    check("rb_late_ready_valid", {31'd0, load_valid_o}, 32'd0);
    check("rb_load_data_cleared", load_data_o, 32'd0);
    dmem_ready_i = 1'b0;
    @(negedge clock);
    #1;
    check("rb_settled_stall", {31'd0, stall_o}, 32'd0);

    // Load result must survive a following store.
    cur_vec = 101;
    v = '{32'h30, 32'h0, 6'h09, 5'd3, 32'h11223344, 1, EV_LOAD, 4'h0, 32'h0, 32'h30, 32'h11223344};
    run_vec(v);
    v = '{32'h34, 32'h55667788, 6'h0A, 5'd0, 32'h0, 2, EV_NONE, 4'hF, 32'h55667788, 32'h34, 32'h0};
    run_vec(v);
    @(negedge clock);
    #1;
    check("hold_load_data", load_data_o, 32'h11223344);
    check("hold_load_reg", {27'd0, load_reg_o}, 32'd3);

    // Back-to-back non-memory instructions never stall.
    cur_vec = 102;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      alu_result_i     = $urandom;
      data_wr_to_mem_i = $urandom;
      mem_signals_i    = 6'($urandom) & 6'b111100;
      #1;
      check("alu_no_stall", {31'd0, stall_o}, 32'd0);
      check("alu_no_req", {31'd0, dmem_req_o}, 32'd0);
    end
    mem_signals_i = 6'd0;

    repeat (3) @(negedge clock);
    #3;
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
